wb_master_bridge: RTL and testbench

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge.sv | 145 ++++++++++++++
 tb/tb_wb_master_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_bridge
// Brief    : Bridges a single-word CPU request/response port onto a classic
//            Wishbone master (cyc/stb/we/ack). Handles one access at a time,
//            rejects misaligned addresses without touching the bus and aborts
//            bus cycles that are not acknowledged within TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_out,
  input  logic [31:0] wb_data_in,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic        wb_ack
);

  // Counter value at which an un-acked bus cycle is abandoned; the counter
  // starts at 0, so the bus cycle lasts exactly TIMEOUT_CYCLES clocks.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  tmo_cnt;

  logic        req_aligned;
  logic        tmo_hit;

  assign req_aligned = (req_addr[1:0] == 2'b00);
  assign tmo_hit     = (tmo_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ack takes priority over the timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = req_aligned ? BUS : RESP;
        end
      end
      BUS: begin
        if (wb_ack || tmo_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, timeout counting and response formation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      tmo_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_aligned) begin
              // Bus-facing copies stay frozen for the whole bus cycle.
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              we_q    <= req_we;
              tmo_cnt <= 8'd0;
            end else begin
              // Misaligned: answer straight away, bus registers untouched.
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end
          end
        end
        BUS: begin
          if (wb_ack) begin
            rdata_q <= we_q ? 32'd0 : wb_data_in;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: bus strobes only while in BUS, response pulse in RESP.
  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign wb_cyc      = (state == BUS);
  assign wb_stb      = (state == BUS);
  assign wb_we       = (state == BUS) && we_q;
  assign wb_addr     = addr_q;
  assign wb_data_out = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_bridge
// Brief    : Self-checking bench for wb_master_bridge. Each transaction is
//            described by (we, addr, wdata, ack delay, read data); the model
//            turns that into the per-cycle trace the outputs must follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_bridge;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_out;
  logic [31:0] wb_data_in;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;

  wb_master_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .wb_addr     (wb_addr),
    .wb_data_out (wb_data_out),
    .wb_data_in  (wb_data_in),
    .wb_we       (wb_we),
    .wb_stb      (wb_stb),
    .wb_cyc      (wb_cyc),
    .wb_ack      (wb_ack)
  );

  always #5 clk = ~clk;

  // One expected output snapshot per clock cycle.
  typedef struct {
    logic        ready;
    logic        cyc;
    logic        we;
    logic        rv;
    logic        err;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_no   = 0;
  int          cyc_hi   = 0;
  int          rsp_at   = -1;
  int          last_acc = 0;
  logic [31:0] rsp_rd   = 32'd0;
  logic        rsp_e    = 1'b0;
  bit          active   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
  endtask

  // Cycle index, advanced at every rising edge.
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Compare process: pops one expected snapshot per cycle; an empty queue means idle.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (active) begin
      if (expq.size() > 0) e = expq.pop_front();
      else e = '{ready:1'b1, cyc:1'b0, we:1'b0, rv:1'b0, err:1'b0, addr:32'd0, dout:32'd0, rdata:32'd0};
      check("req_ready", req_ready, e.ready);
      check("wb_cyc",    wb_cyc,    e.cyc);
      check("wb_stb",    wb_stb,    e.cyc);
      check("wb_we",     wb_we,     e.we);
      check("rsp_valid", rsp_valid, e.rv);
      if (e.cyc) begin
        check("wb_addr",     wb_addr,     e.addr);
        check("wb_data_out", wb_data_out, e.dout);
      end
      if (e.rv) begin
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err",   rsp_err,   e.err);
      end
      if (wb_cyc) cyc_hi++;
      if (rsp_valid) begin
        rsp_at = cyc_no;
        rsp_rd = rsp_rdata;
        rsp_e  = rsp_err;
      end
    end
  end

  // Runs one access; d = BUS cycle index (from 0) carrying ack, d >= T means never.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int d, input logic [31:0] rd, input int gap);
    bit          al;
    int          len;
    logic        err;
    logic [31:0] exp_rd;
    for (int i = 0; i < gap; i++) begin
      req_valid  = 1'b0;
      wb_ack     = 1'($urandom_range(0, 1));
      wb_data_in = $urandom;
      @(posedge clk); #1;
    end
    al     = (addr[1:0] == 2'b00);
    len    = !al ? 0 : ((d < T) ? d + 1 : T);
    err    = !al || (d >= T);
    exp_rd = (err || we) ? 32'd0 : rd;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    wb_ack     = 1'($urandom_range(0, 1));
    wb_data_in = $urandom;
    cyc_hi     = 0;
    @(posedge clk); #1;
    last_acc = cyc_no;
    for (int k = 0; k < len; k++)
      expq.push_back('{ready:1'b0, cyc:1'b1, we:we, rv:1'b0, err:1'b0, addr:addr, dout:wdata, rdata:32'd0});
    expq.push_back('{ready:1'b0, cyc:1'b0, we:1'b0, rv:1'b1, err:err, addr:32'd0, dout:32'd0, rdata:exp_rd});
    for (int k = 0; k < len; k++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      wb_ack     = (k == d);
      wb_data_in = (k == d) ? rd : $urandom;
      @(posedge clk); #1;
    end
    req_valid  = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    wb_ack     = 1'($urandom_range(0, 1));
    wb_data_in = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wb_ack    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; wb_data_in = 32'd0; wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 32'd1);
    check("rst_cyc", wb_cyc, 32'd0);
    check("rst_stb", wb_stb, 32'd0);
    check("rst_we", wb_we, 32'd0);
    check("rst_addr", wb_addr, 32'd0);
    check("rst_dout", wb_data_out, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", rsp_err, 32'd0);
    @(posedge clk); #1;
    active = 1'b1;

    // Read RAM, ack in the third BUS cycle.
    txn(1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1);
    check("ram_rdata", rsp_rd, 32'hDEAD_BEEF);
    check("ram_err", rsp_e, 32'd0);
    check("ram_cyc_cycles", cyc_hi, 32'd3);

    // Write GPIO, ack in first BUS cycle: response two cycles after acceptance.
    txn(1'b1, 32'h2000_0004, 32'h0000_00A5, 0, 32'h5555_5555, 1);
    check("gpio_latency", rsp_at - last_acc, 32'd1);
    check("gpio_rdata", rsp_rd, 32'd0);
    check("gpio_err", rsp_e, 32'd0);

    // Unmapped: no ack, full timeout.
    txn(1'b0, 32'h3000_0000, 32'h0, 1000, 32'h0, 1);
    check("unmap_cyc_cycles", cyc_hi, 32'd16);
    check("unmap_err", rsp_e, 32'd1);
    check("unmap_rdata", rsp_rd, 32'd0);

    // Misaligned: no bus activity, response in the next cycle.
    txn(1'b0, 32'h0000_0002, 32'h0, 0, 32'h1111_1111, 1);
    check("mis_cyc_cycles", cyc_hi, 32'd0);
    check("mis_latency", rsp_at - last_acc, 32'd0);
    check("mis_err", rsp_e, 32'd1);

    // Ack on the 16th BUS cycle wins over the timeout.
    txn(1'b0, 32'h0000_0100, 32'h0, T - 1, 32'h1234_5678, 1);
    check("late_err", rsp_e, 32'd0);
    check("late_rdata", rsp_rd, 32'h1234_5678);
    check("late_cyc_cycles", cyc_hi, 32'd16);

    // Reset during the third BUS cycle aborts the access.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'h0;
    @(posedge clk); #1;
    for (int k = 0; k < T; k++)
      expq.push_back('{ready:1'b0, cyc:1'b1, we:1'b0, rv:1'b0, err:1'b0, addr:32'h40, dout:32'h0, rdata:32'd0});
    req_valid = 1'b0; wb_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    expq.delete();
    rst = 1'b0; cyc_hi = 0; rsp_at = -1;
    @(negedge clk);
    check("abort_addr", wb_addr, 32'd0);
    check("abort_ready", req_ready, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_at, 32'hFFFF_FFFF);
    check("abort_no_cyc", cyc_hi, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      else a[1:0] = 2'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, T + 3), $urandom,
          $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    active = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
